// File: rtl/cv_mem_pkg.sv
// Shared types and constants for the ColecoVision/ADAM memory access sequencer.
package cv_mem_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NUM_CE = 9;

  // CE vector bit positions, listed from highest to lowest priority
  localparam int unsigned CE_BIOS       = 0;
  localparam int unsigned CE_EOS        = 1;
  localparam int unsigned CE_WRITER     = 2;
  localparam int unsigned CE_RAM        = 3;
  localparam int unsigned CE_LOWER_EXP  = 4;
  localparam int unsigned CE_UPPER_RAM  = 5;
  localparam int unsigned CE_EXP_RAM    = 6;
  localparam int unsigned CE_EXP_ROM    = 7;
  localparam int unsigned CE_CART       = 8;

  localparam logic [ADDR_W-1:0] BASE_BIOS    = 23'h000000;
  localparam logic [ADDR_W-1:0] BASE_EOS     = 23'h002000;
  localparam logic [ADDR_W-1:0] BASE_WRITER  = 23'h008000;
  localparam logic [ADDR_W-1:0] BASE_RAM     = 23'h010000;
  localparam logic [ADDR_W-1:0] BASE_EXP_RAM = 23'h020000;
  localparam logic [ADDR_W-1:0] BASE_EXP_ROM = 23'h030000;
  localparam logic [ADDR_W-1:0] BASE_CART    = 23'h400000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  typedef enum logic [3:0] {
    RGN_NONE,
    RGN_BIOS,
    RGN_EOS,
    RGN_WRITER,
    RGN_RAM,
    RGN_LOWER_EXP,
    RGN_UPPER_RAM,
    RGN_EXP_RAM,
    RGN_EXP_ROM,
    RGN_CART
  } region_t;

  function automatic logic is_rom(input region_t r);
    return (r == RGN_BIOS) || (r == RGN_EOS) || (r == RGN_WRITER) ||
           (r == RGN_EXP_ROM) || (r == RGN_CART);
  endfunction

endpackage

// File: rtl/cv_mem_map.sv
// Priority-encodes the decoder chip enables and maps the Z80 address onto
// the flat external memory address space.
module cv_mem_map
  import cv_mem_pkg::*;
(
  input  logic [NUM_CE-1:0] ce_n,
  input  logic [15:0]       a,
  input  logic [5:0]        cart_page,
  output region_t           region_c,
  output logic [ADDR_W-1:0] addr_c
);

  always_comb begin
    region_c = RGN_NONE;
    addr_c   = '0;
    if (!ce_n[CE_BIOS]) begin
      region_c = RGN_BIOS;
      addr_c   = BASE_BIOS + ADDR_W'(a[12:0]);
    end else if (!ce_n[CE_EOS]) begin
      region_c = RGN_EOS;
      addr_c   = BASE_EOS + ADDR_W'(a[12:0]);
    end else if (!ce_n[CE_WRITER]) begin
      region_c = RGN_WRITER;
      addr_c   = BASE_WRITER + ADDR_W'(a[14:0]);
    end else if (!ce_n[CE_RAM]) begin
      region_c = RGN_RAM;
      addr_c   = BASE_RAM + ADDR_W'(a);
    end else if (!ce_n[CE_LOWER_EXP]) begin
      region_c = RGN_LOWER_EXP;
      addr_c   = BASE_EXP_RAM + ADDR_W'(a);
    end else if (!ce_n[CE_UPPER_RAM]) begin
      region_c = RGN_UPPER_RAM;
      addr_c   = BASE_RAM + ADDR_W'(a);
    end else if (!ce_n[CE_EXP_RAM]) begin
      region_c = RGN_EXP_RAM;
      addr_c   = BASE_EXP_RAM + ADDR_W'(a);
    end else if (!ce_n[CE_EXP_ROM]) begin
      region_c = RGN_EXP_ROM;
      addr_c   = BASE_EXP_ROM + ADDR_W'(a[14:0]);
    end else if (!ce_n[CE_CART]) begin
      region_c = RGN_CART;
      addr_c   = BASE_CART + ADDR_W'({cart_page, a[13:0]});
    end
  end

endmodule

// File: rtl/cv_mem_seq.sv
// Turns each Z80 memory cycle into a single request on the flat external
// memory port, stretching the CPU with WAIT until the data returns.
module cv_mem_seq
  import cv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [15:0]       a_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              mreq_n_i,
  input  logic              rd_n_i,
  input  logic              wr_n_i,
  input  logic              rfsh_n_i,
  input  logic              bios_rom_ce_n_i,
  input  logic              eos_rom_ce_n_i,
  input  logic              writer_rom_ce_n_i,
  input  logic              expansion_rom_ce_n_i,
  input  logic              cartridge_rom_ce_n_i,
  input  logic              ram_ce_n_i,
  input  logic              lowerexpansion_ram_ce_n_i,
  input  logic              upper_ram_ce_n_i,
  input  logic              expansion_ram_ce_n_i,
  input  logic [5:0]        cart_page_i,
  output logic              wait_n_o,
  output logic [DATA_W-1:0] d_o,
  output logic              d_oe_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  logic [NUM_CE-1:0] ce_n;
  region_t           region;
  logic [ADDR_W-1:0] map_addr;
  logic              acc_c;
  logic              rom_wr_c;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              err_q, err_d;

  assign ce_n = {cartridge_rom_ce_n_i, expansion_rom_ce_n_i, expansion_ram_ce_n_i,
                 upper_ram_ce_n_i, lowerexpansion_ram_ce_n_i, ram_ce_n_i,
                 writer_rom_ce_n_i, eos_rom_ce_n_i, bios_rom_ce_n_i};

  cv_mem_map u_map (
    .ce_n      (ce_n),
    .a         (a_i),
    .cart_page (cart_page_i),
    .region_c  (region),
    .addr_c    (map_addr)
  );

  // A decoded region implies at least one CE is low; refresh cycles never qualify
  assign acc_c    = !mreq_n_i && rfsh_n_i && (!rd_n_i || !wr_n_i) && (region != RGN_NONE);
  assign rom_wr_c = is_rom(region) && !wr_n_i;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= 8'hFF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (acc_c) begin
          if (rom_wr_c) begin
            // Write-protected: swallow the cycle without touching the port
            state_d = HOLD;
            rd_d    = 1'b0;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = map_addr;
            we_d    = !wr_n_i;
            rd_d    = wr_n_i;
            wdata_d = d_i;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (!we_q) begin
            dout_d = mem_rdata_i;
          end
          req_d   = 1'b0;
          state_d = HOLD;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          dout_d  = 8'hFF;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLD: begin
        if (mreq_n_i || (rd_n_i && wr_n_i)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign wait_n_o    = !((state_q == REQ) || ((state_q == IDLE) && acc_c && !rom_wr_c));
  assign d_oe_o      = (state_q == HOLD) && rd_q && !rd_n_i;
  assign d_o         = dout_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;

endmodule
